bin_to_bcd_disp: RTL and testbench

//  Sequential double-dabble converter upstream of the multiplexed 7-seg driver.

---
 rtl/disp_pkg.sv | 15 +
 rtl/bcd_add3.sv | 15 +
 rtl/bin_to_bcd_disp.sv | 100 ++++++++++
 tb/tb_bin_to_bcd_disp.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
// Pure declarations: no latency, no flow control.
package disp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int          BCD_DIGITS = 5;
    localparam logic [15:0] DISP_MAX   = 16'd9999;
    localparam logic [15:0] DISP_SAT   = 16'h9999;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 when the digit is 5 or more.
// Combinational, zero latency; no flow control.
module bcd_add3 (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    always_comb begin
        nib_out = nib_in;
        if (nib_in >= 4'd5) begin
            nib_out = nib_in + 4'd3;
        end
    end

endmodule

// File: rtl/bin_to_bcd_disp.sv
// Sequential double-dabble to 4 BCD digits with saturation, WIDTH+1 cycles to done.
// Accepts only while ready; bin_valid during a conversion is dropped, never stalled.
module bin_to_bcd_disp
    import disp_pkg::*;
#(
    parameter int          WIDTH  = 16,
    parameter logic [7:0]  OVF_DP = 8'h0F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] bin_in,
    input  logic             bin_valid,
    output logic             ready,
    output logic             done,
    output logic [31:0]      value,
    output logic [7:0]       dp_value
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam int BCD_W = BCD_DIGITS * 4;
    localparam int SR_W  = BCD_W + WIDTH;

    state_t           state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [31:0]      value_q, value_d;
    logic [7:0]       dp_q, dp_d;

    logic [BCD_W-1:0] bcd_adj;
    logic [SR_W-1:0]  sr_shift;

    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nib_in  (sr_q[WIDTH + 4*g +: 4]),
            .nib_out (bcd_adj[4*g +: 4])
        );
    end

    assign sr_shift = {bcd_adj, sr_q[WIDTH-1:0]} << 1;

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        value_d = value_q;
        dp_d    = dp_q;
        case (state_q)
            ST_IDLE: begin
                if (bin_valid) begin
                    sr_d    = {{BCD_W{1'b0}}, bin_in};
                    cnt_d   = '0;
                    ovf_d   = 32'(bin_in) > 32'(DISP_MAX);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sr_d  = sr_shift;
                cnt_d = cnt_q + CNT_W'(1);
                // Outputs update only here, so the display never sees partial digits.
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    value_d = ovf_q ? {16'h0, DISP_SAT} : {16'h0, sr_shift[WIDTH +: 16]};
                    dp_d    = ovf_q ? OVF_DP : 8'h00;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
            value_q <= 32'h0;
            dp_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            value_q <= value_d;
            dp_q    <= dp_d;
        end
    end

    assign ready    = (state_q == ST_IDLE);
    assign done     = (state_q == ST_DONE);
    assign value    = value_q;
    assign dp_value = dp_q;

endmodule

// File: tb/tb_bin_to_bcd_disp.sv
// Directed and random bench for bin_to_bcd_disp with a result scoreboard.
module tb_bin_to_bcd_disp;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] bin_in;
    logic        bin_valid;
    logic        ready;
    logic        done;
    logic [31:0] value;
    logic [7:0]  dp_value;

    int          checks = 0;
    int          errors = 0;
    logic [39:0] exp_q[$];
    logic [31:0] last_value;

    bin_to_bcd_disp #(.WIDTH(16), .OVF_DP(8'h0F)) dut (
        .clk       (clk),
        .rst       (rst),
        .bin_in    (bin_in),
        .bin_valid (bin_valid),
        .ready     (ready),
        .done      (done),
        .value     (value),
        .dp_value  (dp_value)
    );

    always #5 clk = ~clk;

    // Reference: saturate at 9999, digits by division, DP mask on overflow.
    function automatic logic [39:0] model(input int x);
        logic [31:0] v;
        if (x > 9999) return {32'h0000_9999, 8'h0F};
        v = {16'h0, 4'(x / 1000), 4'((x / 100) % 10), 4'((x / 10) % 10), 4'(x % 10)};
        return {v, 8'h00};
    endfunction

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [15:0] x, input bit scored);
        int n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_send", 40'(ready), 40'd1);
        bin_in    = x;
        bin_valid = 1'b1;
        if (scored) exp_q.push_back(model(int'(x)));
        @(posedge clk);
        #1 bin_valid = 1'b0;
    endtask

    task automatic wait_done(output int k);
        bit          got = 1'b0;
        logic [39:0] exp;
        k = 0;
        while (k < 40 && !got) begin
            @(negedge clk);
            k++;
            if (done) got = 1'b1;
            else chk("hold_value", 40'(value), 40'(last_value));
        end
        chk("done_seen", 40'(got), 40'd1);
        if (got) begin
            chk("sb_nonempty", 40'(exp_q.size() > 0), 40'd1);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                chk("result", {value, dp_value}, exp);
            end
            last_value = value;
        end
    endtask

    initial begin
        int          k;
        int          ndone;
        int          last_done;
        logic [15:0] bvals[5];

        rst        = 1'b1;
        bin_valid  = 1'b0;
        bin_in     = 16'h0;
        last_value = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state and quiet idle
        @(negedge clk);
        chk("rst_ready", 40'(ready), 40'd1);
        chk("rst_value", 40'(value), 40'h0);
        chk("rst_dp", 40'(dp_value), 40'h0);
        ndone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("idle_no_done", 40'(ndone), 40'd0);

        // Single conversion with latency
        send(16'd1234, 1'b1);
        wait_done(k);
        chk("latency", 40'(k), 40'd17);
        chk("ready_low_in_done", 40'(ready), 40'd0);
        @(negedge clk);
        chk("ready_after_done", 40'(ready), 40'd1);
        chk("done_one_cycle", 40'(done), 40'd0);

        // Boundaries
        bvals = '{16'd0, 16'd9, 16'd9999, 16'd10000, 16'd65535};
        for (int i = 0; i < 5; i++) begin
            send(bvals[i], 1'b1);
            wait_done(k);
        end

        // Valid held high with bin_in changing every cycle
        @(negedge clk);
        ndone     = 0;
        last_done = -1;
        bin_valid = 1'b1;
        for (int c = 0; c < 90; c++) begin
            if (c > 0) @(negedge clk);
            if (done) begin
                chk("sb_nonempty", 40'(exp_q.size() > 0), 40'd1);
                if (exp_q.size() > 0) chk("stream_result", {value, dp_value}, exp_q.pop_front());
                if (last_done >= 0) chk("stream_period", 40'(c - last_done), 40'd18);
                last_done  = c;
                last_value = value;
                ndone++;
            end else begin
                chk("stream_hold", 40'(value), 40'(last_value));
            end
            bin_in = 16'(c * 397 + 3);
            if (ready) exp_q.push_back(model(int'(bin_in)));
        end
        bin_valid = 1'b0;
        chk("stream_dones", 40'(ndone), 40'd5);
        chk("stream_sb_empty", 40'(exp_q.size()), 40'd0);

        // Reset during SHIFT aborts without a done pulse
        send(16'd4321, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_value", 40'(value), 40'h0);
        chk("abort_dp", 40'(dp_value), 40'h0);
        chk("abort_ready", 40'(ready), 40'd1);
        chk("abort_done", 40'(done), 40'd0);
        last_value = 32'h0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", 40'(ndone), 40'd0);
        send(16'd42, 1'b1);
        wait_done(k);

        // Reset wins over a simultaneous bin_valid
        @(negedge clk);
        rst       = 1'b1;
        bin_valid = 1'b1;
        bin_in    = 16'd99;
        @(posedge clk);
        #1 rst = 1'b0;
        bin_valid = 1'b0;
        ndone = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("rst_valid_no_done", 40'(ndone), 40'd0);
        chk("rst_valid_value", 40'(value), 40'h0);
        chk("rst_valid_ready", 40'(ready), 40'd1);
        last_value = 32'h0;

        // Random sweep
        for (int i = 0; i < 30; i++) begin
            send(16'($urandom_range(0, 65535)), 1'b1);
            wait_done(k);
            chk("rand_latency", 40'(k), 40'd17);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
